// File: rtl/pipe_pkg.sv
// Shared types and per-stage default widths for the MIPS pipeline stage registers.
package pipe_pkg;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;   // pc_plus4, instruction
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 143;  // pc_plus4, rs/rt data, imm, rt, rd, shamt
  localparam int EXMEM_CTRL_W = 6;
  localparam int EXMEM_DATA_W = 101;  // add_result, alu_result, read_data_2, reg_dest
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;   // read_data, alu_result, reg_dest

endpackage

// File: rtl/pipe_entry.sv
// One stored pipeline entry: load-enabled register, async active-low reset to zero.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline-stage register with flush, bubble clearing
// and an optional skid entry that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 6,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int EW = CTRL_W + DATA_W;

  state_e        state, nxt;
  logic          accept, drain;
  logic          head_ld, skid_ld, from_skid;
  logic [EW-1:0] head_d, head_q, skid_q;

  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign occupancy = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    head_ld   = 1'b0;
    skid_ld   = 1'b0;
    from_skid = 1'b0;
    unique case (state)
      S_EMPTY: if (accept) begin
        nxt     = S_FULL;
        head_ld = 1'b1;
      end
      S_FULL: begin
        // Without a skid entry an accept in FULL implies a same-cycle drain.
        if (accept && (drain || !SKID)) head_ld = 1'b1;
        else if (accept) begin
          nxt     = S_SKID;
          skid_ld = 1'b1;
        end
        else if (drain) nxt = S_EMPTY;
      end
      S_SKID: if (drain) begin
        nxt       = S_FULL;
        head_ld   = 1'b1;
        from_skid = 1'b1;
      end
      default: nxt = S_EMPTY;
    endcase
    // Flush wins over everything; loads are suppressed so killed data never shows.
    if (flush) begin
      nxt     = S_EMPTY;
      head_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  assign head_d = from_skid ? skid_q : {in_ctrl, in_data};

  pipe_entry #(.W(EW)) u_head (
    .clk(clk), .rst_n(rst_n), .ld(head_ld), .d(head_d), .q(head_q)
  );

  generate
    if (SKID) begin : g_skid
      logic rdy_q;

      pipe_entry #(.W(EW)) u_skid (
        .clk(clk), .rst_n(rst_n), .ld(skid_ld), .d({in_ctrl, in_data}), .q(skid_q)
      );

      // Registered ready: no combinational path from out_ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= (nxt != S_SKID);
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign skid_q   = '0;
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  assign out_ctrl = head_q[EW-1:DATA_W] & {CTRL_W{out_valid}};
  assign out_data = head_q[DATA_W-1:0];

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register for the 32-bit MIPS pipeline, superseding the fixed-width, always-loading stage registers between IF/ID/EX/MEM/WB. It carries a control field and a data payload of configurable width under a valid/ready handshake, supports stall and flush, and forces control bits to zero on bubbles so hazard logic can insert NOPs. With SKID=1 a second entry breaks the combinational ready path between stages.

## Interface
- DATA_W, 101: payload width (e.g. add_result, alu_result, read_data_2, register_dest = 32+32+32+5).
- CTRL_W, 6: control-field width (e.g. MemtoReg, RegWrite, MemRead, MemWrite, Branch, zero); cleared on bubble.
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single entry with pass-through ready.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  control bits from upstream.
- in_data  in  DATA_W  payload from upstream.
- flush  in  1  synchronous kill of all held entries (branch taken / exception).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head this cycle; low = stall.
- out_ctrl  out  CTRL_W  head control bits; all zero whenever out_valid=0.
- out_data  out  DATA_W  head payload; holds last value when out_valid=0.
- occupancy  out  2  entries held (0..2; never exceeds 1 when SKID=0).

## Operation
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset (rst_n=0, asynchronous): occupancy=0, out_valid=0, out_ctrl=0, out_data=0; in_ready=1 in the first cycle after release.
- SKID=1 states, stored in a state register:
  - EMPTY (occ 0): accept -> FULL, head loaded.
  - FULL (occ 1): accept & drain -> FULL, head reloaded; accept only -> SKID, input captured in skid entry; drain only -> EMPTY.
  - SKID (occ 2): in_ready=0; drain -> FULL, skid entry moves to head; otherwise hold.
- in_ready (SKID=1) = state != SKID, a flop output with no combinational path from out_ready.
- SKID=0: single entry; in_ready = ~out_valid | out_ready (combinational); accept & drain in one cycle reloads head.
- Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- flush: next state EMPTY regardless of accept/drain in the same cycle; a same-cycle accepted input is discarded; a same-cycle drain still completes downstream (its head was valid this cycle).
- flush is evaluated before stall: a stalled (out_ready=0) stage still empties on flush.
- Bubble clearing: out_ctrl = head_ctrl & {CTRL_W{out_valid}}, so a stalled-empty or flushed stage presents all-zero control (no RegWrite/MemWrite).
- Payload registers load only on accept or skid-to-head move (clock-enable, no reset needed on the data path beyond the reset value of zero).

## Timing
- Latency: input accepted at edge N is on out_* after edge N (visible cycle N+1) when the stage is EMPTY or draining.
- Throughput: one transfer per cycle sustained with out_ready=1 in both modes.
- SKID=1: in_ready falls one cycle after the accept that fills the skid entry; it rises the cycle after the drain that frees it.
- flush takes effect at the next edge: out_valid=0, occupancy=0, in_ready=1 from the following cycle.
- rst_n assertion mid-transfer clears state immediately, without waiting for clk.

## Structure
- Shared package pipe_pkg: typedef enum for state {EMPTY, FULL, SKID} (2-bit), default width constants for each pipeline stage (IFID/IDEX/EXMEM/MEMWB CTRL_W and DATA_W).
- One sub-module natural: pipe_entry (CTRL_W+DATA_W register with load enable and async active-low reset), instantiated as head and skid entry; skid entry omitted under SKID=0 via generate.
- Existing fixed stage registers become instances with stage-specific parameters.

## Test plan
- Reset then stream 0x1..0x8 with out_ready=1 (both modes) -> outputs 0x1..0x8 in order, one per cycle, first at cycle 1 after first accept, occupancy stays 1.
- SKID=1, fill with A, B while out_ready=0 -> occupancy=2, in_ready=0, out_data=A held; raise out_ready -> A then B, in_ready=1 one cycle after A drains.
- SKID=0, out_ready=0 with out_valid=1 -> in_ready=0 same cycle; in_valid held with C -> C accepted in the cycle out_ready rises.
- Occupancy 2, assert flush together with in_valid=1 carrying D -> next cycle out_valid=0, out_ctrl=0, occupancy=0, D never appears at output.
- in_ctrl=6'b111111 with in_valid=0 for 3 cycles -> out_ctrl=0 throughout; then accept ctrl 6'b010100 -> out_ctrl=6'b010100 one cycle later.
- Pull rst_n low between edges while occupancy=2 -> out_valid, out_ctrl, occupancy drop to 0 immediately; after release the stream restarts cleanly.
